la_ioring_seq: RTL and testbench
================================

Name: la_ioring_seq

Overview:
- Power-up/power-down sequencer for the padring: corner pads, supply pads and signal IO cells.
- After supply-good, it enables the ring, releases pad hold, then enables output drivers group by group with programmable gaps. Power-down runs in exact reverse.
- Sits in the always-on core domain beside the padring. It is the only source of ring enable, hold and per-group drive-enable controls.

Parameters:
- NGROUPS, 4, number of independently enabled pad groups (sides/banks), 1..16
- CNTW, 8, width of the inter-step delay counter
- TIMEOUT, 1024, watchdog limit in cycles for supply-good (used only with the optional feature)

Ports:
- clk  input  1  sequencer clock
- reset  input  1  synchronous, active-high reset
- pwr_good  input  1  asynchronous io-supply-good flag; synchronized internally (2 flops)
- up_req  input  1  level request to power the ring up
- down_req  input  1  level request to power the ring down; wins over up_req
- dly  input  CNTW  per-step gap in cycles; sampled at each step entry
- ring_en  output  1  enables ring-level biasing (ioring enable controls)
- hold  output  1  pad state hold; 1 = outputs frozen
- grp_en  output  NGROUPS  per-group output-driver enable
- ready  output  1  ring fully up (ACTIVE state)
- busy  output  1  sequence in progress
- fault  output  1  sticky supply-loss/timeout flag

Behaviour:
- Reset state: state=OFF, ring_en=0, hold=1, grp_en=0, ready=0, busy=0, fault=0, sync flops=0.
- All outputs are registered and reflect the state one cycle after the transition decision.
- pg_s is the synchronized pwr_good (2-cycle latency).
- Step timer:
  - Loads dly on entry to every timed state, then counts down.
  - The state advances on the cycle the count equals 0.
  - dly=0 gives 1 cycle in the state; dly=N gives N+1 cycles.
- States and transitions:
  - OFF: on up_req && !down_req -> WAIT_PG.
  - WAIT_PG (busy): pg_s=1 -> RING_ON; down_req -> OFF.
  - RING_ON (timed): ring_en=1; on timer done -> RELEASE.
  - RELEASE (timed): hold=0; on timer done -> GRP_ON with idx=0.
  - GRP_ON (timed): grp_en[idx]=1 on entry. On timer done: idx==NGROUPS-1 -> ACTIVE, else idx+1 and re-enter GRP_ON.
  - ACTIVE: ready=1, busy=0. down_req -> GRP_OFF with idx=NGROUPS-1.
  - GRP_OFF (timed): grp_en[idx]=0 on entry. On timer done: idx==0 -> HOLD_ON, else idx-1.
  - HOLD_ON (timed): hold=1; on timer done -> RING_OFF.
  - RING_OFF (timed): ring_en=0; on timer done -> OFF.
  - FAULT: ring_en=0, hold=1, grp_en=0, fault=1. Exit to WAIT_PG on up_req && pg_s && !down_req; fault clears on that exit.
- busy=1 in every state except OFF, ACTIVE and FAULT.
- down_req during any power-up state (RING_ON..GRP_ON) aborts into the reverse path:
  - From GRP_ON it enters GRP_OFF at the current idx (that group was already enabled).
  - From RELEASE it enters HOLD_ON.
  - From RING_ON it enters RING_OFF.
- up_req during a power-down state is ignored until OFF is reached.
- Supply loss: pg_s=0 in any state other than OFF, WAIT_PG or FAULT -> FAULT next cycle. It skips ordered teardown and overrides down_req.
- Simultaneous up_req and down_req: down_req wins.
- reset asserted mid-sequence: immediate return to the reset state on the next edge. Outputs are safe (hold=1, all enables 0).
- idx width is $clog2(NGROUPS), minimum 1.

Optional Feature:
- Macro: LA_IOSEQ_WDOG_EN.
- With the macro:
  - A watchdog counter runs while in WAIT_PG.
  - If pg_s stays 0 for TIMEOUT cycles -> FAULT.
  - The counter clears on WAIT_PG exit.
- Without the macro: WAIT_PG waits indefinitely; the TIMEOUT parameter is unused and the counter is not instantiated.

Decomposition:
- Package la_ioseq_pkg:
  - State enum (OFF, WAIT_PG, RING_ON, RELEASE, GRP_ON, ACTIVE, GRP_OFF, HOLD_ON, RING_OFF, FAULT), 4-bit encoding.
  - Localparam for the sync depth (2).
- Sub-module la_ioseq_timer: loadable CNTW-bit down-counter with load/done ports. It is reused for the watchdog.

Test Plan:
- Nominal up: reset, pwr_good=1, dly=3, NGROUPS=4, up_req=1 ->
  - ring_en rises after sync.
  - hold falls 4 cycles later.
  - grp_en goes 0001, 0011, 0111, 1111 at 4-cycle spacing.
  - ready=1 four cycles after the last group.
- Nominal down from ACTIVE: down_req=1 ->
  - grp_en goes 0111, 0011, 0001, 0000 at 4-cycle spacing.
  - Then hold=1, then ring_en=0; busy=0 in OFF.
- Abort: down_req while grp_en=0011 (idx=1) -> grp_en goes 0001, then 0000; ordered teardown; ends in OFF, never ready.
- Supply loss: drop pwr_good in ACTIVE -> 3 cycles later (sync+1) grp_en=0, hold=1, ring_en=0, fault=1. Restore pwr_good plus up_req -> fault=0 and the sequence restarts.
- dly=0 and simultaneous up_req/down_req:
  - dly=0: each timed step lasts exactly 1 cycle.
  - Both requests high in OFF: the block stays in OFF.
- Watchdog (LA_IOSEQ_WDOG_EN, TIMEOUT=16): up_req with pwr_good=0 -> fault=1 after 16 cycles in WAIT_PG. Without the macro the block stays in WAIT_PG with fault=0.

Source files
------------

// File: rtl/la_ioseq_pkg.sv
// Shared types for the padring power sequencer.
// Provides the state encoding, sync depth and a timed-state helper.
package la_ioseq_pkg;

   localparam int SYNC_D = 2;

   typedef enum logic [3:0] {
      OFF      = 4'd0,
      WAIT_PG  = 4'd1,
      RING_ON  = 4'd2,
      RELEASE  = 4'd3,
      GRP_ON   = 4'd4,
      ACTIVE   = 4'd5,
      GRP_OFF  = 4'd6,
      HOLD_ON  = 4'd7,
      RING_OFF = 4'd8,
      FAULT    = 4'd9
   } seq_st_t;

   function automatic logic is_timed(input seq_st_t s);
      return (s == RING_ON) || (s == RELEASE) ||
             (s == GRP_ON)  || (s == GRP_OFF) ||
             (s == HOLD_ON) || (s == RING_OFF);
   endfunction

endpackage

// File: rtl/la_ioring_seq_if.sv
// Request/status bundle between the core and the padring sequencer.
// master: drives supply flag, requests, step gap; slave: drives ring controls.
interface la_ioring_seq_if #(
   parameter int NGROUPS = 4,
   parameter int CNTW    = 8
);
   logic               pwr_good;
   logic               up_req;
   logic               down_req;
   logic [CNTW-1:0]    dly;
   logic               ring_en;
   logic               hold;
   logic [NGROUPS-1:0] grp_en;
   logic               ready;
   logic               busy;
   logic               fault;

   modport master (
      output pwr_good, up_req, down_req, dly,
      input  ring_en, hold, grp_en, ready, busy, fault
   );

   modport slave (
      input  pwr_good, up_req, down_req, dly,
      output ring_en, hold, grp_en, ready, busy, fault
   );
endinterface

// File: rtl/la_ioseq_timer.sv
// Loadable down-counter; done while the count is zero, saturates at zero.
// Ports: clk, reset (sync, high), load, val[W], done.
module la_ioseq_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/la_ioring_seq.sv
// Padring power-up/down sequencer: ring enable, pad hold, per-group drivers.
// Ports: clk, reset (sync, high), bus (slave modport of la_ioring_seq_if).
// Optional supply-good watchdog in WAIT_PG: define LA_IOSEQ_WDOG_EN.
module la_ioring_seq
   import la_ioseq_pkg::*;
#(
   parameter int NGROUPS = 4,
   parameter int CNTW    = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic           clk,
   input  logic           reset,
   la_ioring_seq_if.slave bus
);

   localparam int IW = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
   localparam logic [IW-1:0] LAST = IW'(NGROUPS - 1);

   if (NGROUPS < 1 || NGROUPS > 16 || TIMEOUT < 2) begin : g_badcfg
      $error("la_ioring_seq: unsupported parameters");
   end

   seq_st_t             st, st_n;
   logic [IW-1:0]       idx, idx_n;
   logic [SYNC_D-1:0]   sync;
   logic                pg_s;
   logic                ld;
   logic                tdone;
   logic                wd_to;

   logic                ring_n, hold_n, ready_n, busy_n, fault_n;
   logic [NGROUPS-1:0]  grp_n;
   logic                ring_q, hold_q, ready_q, busy_q, fault_q;
   logic [NGROUPS-1:0]  grp_q;

   assign pg_s = sync[SYNC_D-1];

   // Step gap timer, reloaded whenever a timed step is (re)entered.
   assign ld = is_timed(st_n) && ((st_n != st) || (idx_n != idx));

   la_ioseq_timer #(.W(CNTW)) u_step (
      .clk   (clk),
      .reset (reset),
      .load  (ld),
      .val   (bus.dly),
      .done  (tdone)
   );

`ifdef LA_IOSEQ_WDOG_EN
   localparam int WDW = $clog2(TIMEOUT);

   // Held loaded outside WAIT_PG, so it restarts on every entry.
   la_ioseq_timer #(.W(WDW)) u_wdog (
      .clk   (clk),
      .reset (reset),
      .load  (st != WAIT_PG),
      .val   (WDW'(TIMEOUT - 1)),
      .done  (wd_to)
   );
`else
   assign wd_to = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         sync    <= '0;
         st      <= OFF;
         idx     <= '0;
         ring_q  <= 1'b0;
         hold_q  <= 1'b1;
         grp_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         sync    <= {sync[SYNC_D-2:0], bus.pwr_good};
         st      <= st_n;
         idx     <= idx_n;
         ring_q  <= ring_n;
         hold_q  <= hold_n;
         grp_q   <= grp_n;
         ready_q <= ready_n;
         busy_q  <= busy_n;
         fault_q <= fault_n;
      end
   end

   // Supply loss beats down_req; down_req beats the step timer.
   always_comb begin
      st_n  = st;
      idx_n = idx;
      unique case (st)
         OFF: begin
            if (bus.up_req && !bus.down_req) st_n = WAIT_PG;
         end
         WAIT_PG: begin
            if (bus.down_req)  st_n = OFF;
            else if (pg_s)     st_n = RING_ON;
            else if (wd_to)    st_n = FAULT;
         end
         RING_ON: begin
            if (!pg_s)             st_n = FAULT;
            else if (bus.down_req) st_n = RING_OFF;
            else if (tdone)        st_n = RELEASE;
         end
         RELEASE: begin
            if (!pg_s)             st_n = FAULT;
            else if (bus.down_req) st_n = HOLD_ON;
            else if (tdone) begin
               st_n  = GRP_ON;
               idx_n = '0;
            end
         end
         GRP_ON: begin
            if (!pg_s)             st_n = FAULT;
            else if (bus.down_req) st_n = GRP_OFF;
            else if (tdone) begin
               if (idx == LAST) st_n  = ACTIVE;
               else             idx_n = idx + 1'b1;
            end
         end
         ACTIVE: begin
            if (!pg_s) st_n = FAULT;
            else if (bus.down_req) begin
               st_n  = GRP_OFF;
               idx_n = LAST;
            end
         end
         GRP_OFF: begin
            if (!pg_s) st_n = FAULT;
            else if (tdone) begin
               if (idx == '0) st_n  = HOLD_ON;
               else           idx_n = idx - 1'b1;
            end
         end
         HOLD_ON: begin
            if (!pg_s)      st_n = FAULT;
            else if (tdone) st_n = RING_OFF;
         end
         RING_OFF: begin
            if (!pg_s)      st_n = FAULT;
            else if (tdone) st_n = OFF;
         end
         FAULT: begin
            if (bus.up_req && pg_s && !bus.down_req) st_n = WAIT_PG;
         end
         default: st_n = OFF;
      endcase
   end

   // Outputs decoded from the next state so they land with the state.
   // GRP_ON idx: groups 0..idx on; GRP_OFF idx: groups below idx on.
   always_comb begin
      ring_n  = (st_n == RING_ON) || (st_n == RELEASE) ||
                (st_n == GRP_ON)  || (st_n == ACTIVE)  ||
                (st_n == GRP_OFF) || (st_n == HOLD_ON);
      hold_n  = !((st_n == RELEASE) || (st_n == GRP_ON) ||
                  (st_n == ACTIVE)  || (st_n == GRP_OFF));
      ready_n = (st_n == ACTIVE);
      fault_n = (st_n == FAULT);
      busy_n  = !((st_n == OFF) || (st_n == ACTIVE) || (st_n == FAULT));
      grp_n   = '0;
      for (int i = 0; i < NGROUPS; i++) begin
         grp_n[i] = (st_n == ACTIVE) ||
                    ((st_n == GRP_ON)  && (IW'(i) <= idx_n)) ||
                    ((st_n == GRP_OFF) && (IW'(i) <  idx_n));
      end
   end

   assign bus.ring_en = ring_q;
   assign bus.hold    = hold_q;
   assign bus.grp_en  = grp_q;
   assign bus.ready   = ready_q;
   assign bus.busy    = busy_q;
   assign bus.fault   = fault_q;

endmodule

// File: tb/tb_la_ioring_seq.sv
// Directed bench for la_ioring_seq (NGROUPS=4, CNTW=8, TIMEOUT=16).
// Status vector checked as {ring_en, hold, grp_en[3:0], ready, busy, fault}.
module tb_la_ioring_seq;

   logic clk = 1'b0;
   logic reset;
   int   nchk = 0;
   int   nerr = 0;
   logic ready_seen;

   always #5 clk = ~clk;

   la_ioring_seq_if #(.NGROUPS(4), .CNTW(8)) bus ();

   la_ioring_seq #(
      .NGROUPS (4),
      .CNTW    (8),
      .TIMEOUT (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [8:0] obs;
   assign obs = {bus.ring_en, bus.hold, bus.grp_en,
                 bus.ready, bus.busy, bus.fault};

   always @(posedge clk) if (bus.ready === 1'b1) ready_seen = 1'b1;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      bus.pwr_good = 1'b0;
      bus.up_req   = 1'b0;
      bus.down_req = 1'b0;
      bus.dly      = 8'd3;
      cyc(3);
      nchk++;
      if (obs !== 9'b0_1_0000_000) begin
         nerr++;
         $display("FAIL reset got %b exp %b", obs, 9'b0_1_0000_000);
      end
      reset = 1'b0;
      cyc(1);
      nchk++;
      if (obs !== 9'b0_1_0000_000) begin
         nerr++;
         $display("FAIL reset_idle got %b exp %b", obs, 9'b0_1_0000_000);
      end
   endtask

   task automatic test_nominal_up();
      int         w[11] = '{1, 1, 1, 3, 1, 4, 4, 4, 4, 3, 1};
      logic [8:0] e[11] = '{
         9'b0_1_0000_010, 9'b0_1_0000_010, 9'b1_1_0000_010,
         9'b1_1_0000_010, 9'b1_0_0000_010, 9'b1_0_0001_010,
         9'b1_0_0011_010, 9'b1_0_0111_010, 9'b1_0_1111_010,
         9'b1_0_1111_010, 9'b1_0_1111_100};
      bus.pwr_good = 1'b1;
      bus.dly      = 8'd3;
      bus.up_req   = 1'b1;
      for (int k = 0; k < 11; k++) begin
         cyc(w[k]);
         nchk++;
         if (obs !== e[k]) begin
            nerr++;
            $display("FAIL up[%0d] got %b exp %b", k, obs, e[k]);
         end
      end
   endtask

   task automatic test_nominal_down();
      int         w[7] = '{1, 4, 4, 4, 4, 4, 4};
      logic [8:0] e[7] = '{
         9'b1_0_0111_010, 9'b1_0_0011_010, 9'b1_0_0001_010,
         9'b1_0_0000_010, 9'b1_1_0000_010, 9'b0_1_0000_010,
         9'b0_1_0000_000};
      bus.up_req   = 1'b0;
      bus.down_req = 1'b1;
      for (int k = 0; k < 7; k++) begin
         cyc(w[k]);
         nchk++;
         if (obs !== e[k]) begin
            nerr++;
            $display("FAIL down[%0d] got %b exp %b", k, obs, e[k]);
         end
      end
      bus.down_req = 1'b0;
   endtask

   task automatic test_abort();
      int         w[10] = '{1, 1, 4, 4, 4, 1, 4, 4, 4, 4};
      logic [8:0] e[10] = '{
         9'b0_1_0000_010, 9'b1_1_0000_010, 9'b1_0_0000_010,
         9'b1_0_0001_010, 9'b1_0_0011_010, 9'b1_0_0001_010,
         9'b1_0_0000_010, 9'b1_1_0000_010, 9'b0_1_0000_010,
         9'b0_1_0000_000};
      ready_seen = 1'b0;
      bus.up_req = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k == 5) begin
            bus.up_req   = 1'b0;
            bus.down_req = 1'b1;
         end
         cyc(w[k]);
         nchk++;
         if (obs !== e[k]) begin
            nerr++;
            $display("FAIL abort[%0d] got %b exp %b", k, obs, e[k]);
         end
      end
      bus.down_req = 1'b0;
      nchk++;
      if (ready_seen !== 1'b0) begin
         nerr++;
         $display("FAIL abort_ready got %b exp %b", ready_seen, 1'b0);
      end
   endtask

   task automatic test_dly0_supply_loss();
      int         w[15] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 1, 2, 1, 1, 1, 1};
      logic [8:0] e[15] = '{
         9'b0_1_0000_010, 9'b1_1_0000_010, 9'b1_0_0000_010,
         9'b1_0_0001_010, 9'b1_0_0011_010, 9'b1_0_0111_010,
         9'b1_0_1111_010, 9'b1_0_1111_100, 9'b1_0_1111_100,
         9'b0_1_0000_001, 9'b0_1_0000_001, 9'b0_1_0000_010,
         9'b1_1_0000_010, 9'b0_1_0000_010, 9'b0_1_0000_000};
      bus.dly    = 8'd0;
      bus.up_req = 1'b1;
      for (int k = 0; k < 15; k++) begin
         if (k == 8) begin
            bus.pwr_good = 1'b0;
            bus.up_req   = 1'b0;
         end
         if (k == 10) begin
            bus.pwr_good = 1'b1;
            bus.up_req   = 1'b1;
         end
         if (k == 13) begin
            bus.up_req   = 1'b0;
            bus.down_req = 1'b1;
         end
         cyc(w[k]);
         nchk++;
         if (obs !== e[k]) begin
            nerr++;
            $display("FAIL dly0_loss[%0d] got %b exp %b", k, obs, e[k]);
         end
      end
      bus.down_req = 1'b0;
   endtask

   task automatic test_both_req();
      bus.up_req   = 1'b1;
      bus.down_req = 1'b1;
      cyc(3);
      nchk++;
      if (obs !== 9'b0_1_0000_000) begin
         nerr++;
         $display("FAIL both_req got %b exp %b", obs, 9'b0_1_0000_000);
      end
      bus.up_req   = 1'b0;
      bus.down_req = 1'b0;
   endtask

   task automatic test_watchdog();
      bus.pwr_good = 1'b0;
      cyc(3);
      bus.up_req = 1'b1;
`ifdef LA_IOSEQ_WDOG_EN
      cyc(16);
      nchk++;
      if (obs !== 9'b0_1_0000_010) begin
         nerr++;
         $display("FAIL wdog_wait got %b exp %b", obs, 9'b0_1_0000_010);
      end
      cyc(1);
      nchk++;
      if (obs !== 9'b0_1_0000_001) begin
         nerr++;
         $display("FAIL wdog_fault got %b exp %b", obs, 9'b0_1_0000_001);
      end
`else
      cyc(17);
      nchk++;
      if (obs !== 9'b0_1_0000_010) begin
         nerr++;
         $display("FAIL wdog_none got %b exp %b", obs, 9'b0_1_0000_010);
      end
`endif
   endtask

   task automatic test_mid_reset();
      reset = 1'b1;
      cyc(1);
      nchk++;
      if (obs !== 9'b0_1_0000_000) begin
         nerr++;
         $display("FAIL mid_reset got %b exp %b", obs, 9'b0_1_0000_000);
      end
      reset      = 1'b0;
      bus.up_req = 1'b0;
      cyc(2);
      nchk++;
      if (obs !== 9'b0_1_0000_000) begin
         nerr++;
         $display("FAIL post_reset got %b exp %b", obs, 9'b0_1_0000_000);
      end
   endtask

   initial begin
      test_reset();
      test_nominal_up();
      test_nominal_down();
      test_abort();
      test_dly0_supply_loss();
      test_both_req();
      test_watchdog();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nerr);
      $finish;
   end

endmodule
